fft_frame_scheduler: RTL and testbench
======================================

// Module: fft_frame_scheduler
// PURPOSE
//  Sequences the streaming FFT core for pitch detection, entirely in the fft_clk domain (samples arrive post-CDC).
//  Gathers NSamples audio samples into one framed FFT input burst (sop/eop) and waits for the FFT output frame.
//  Scans bin magnitudes for the peak and reports the peak bin as pitch_output_data with a one-cycle valid.
// PARAMETERS
//  NSamples  1024     FFT frame length, power of two
//  W         16       audio sample width
//  MAG_W     32       FFT magnitude width (unsigned)
//  MIN_BIN   2        lowest bin eligible for the peak (rejects DC/rumble)
//  TIMEOUT   8192     max fft_clk cycles in WAIT_OUT before abort
// PORTS
//  fft_clk             in   1        sole clock
//  reset               in   1        asynchronous, active-low reset
//  enable              in   1        permits a new frame to start (sampled in IDLE only)
//  sample_data         in   W        audio sample from CDC FIFO
//  sample_valid        in   1        sample_data valid
//  sample_ready        out  1        scheduler accepts sample this cycle
//  fft_in_data         out  W        sample to FFT core
//  fft_in_valid        out  1        fft_in_data valid
//  fft_in_sop          out  1        first sample of frame
//  fft_in_eop          out  1        last sample of frame
//  fft_in_ready        in   1        FFT core accepts input
//  fft_out_mag         in   MAG_W    bin magnitude from FFT core
//  fft_out_valid       in   1        fft_out_mag valid
//  fft_out_sop         in   1        bin 0 of output frame
//  fft_out_eop         in   1        bin NSamples-1 of output frame
//  pitch_output_data   out  $clog2(NSamples)  peak bin index of last good frame
//  pitch_output_valid  out  1        one-cycle pulse: new pitch_output_data
//  sync_error          out  1        sticky; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; counters, peak_mag, peak_bin cleared.
//  States: IDLE -> LOAD -> WAIT_OUT -> SCAN -> REPORT -> IDLE.
//  IDLE: sample_ready=0. enable=1 -> LOAD next cycle; enable=0 stays IDLE.
//  LOAD: fft_in_data=sample_data, fft_in_valid=sample_valid, sample_ready=fft_in_ready (combinational pass-through).
//   Transfer = sample_valid & fft_in_ready; in_cnt 0..NSamples-1 increments per transfer.
//   fft_in_sop=1 when in_cnt==0, fft_in_eop=1 when in_cnt==NSamples-1 (qualified by fft_in_valid).
//   Transfer at in_cnt==NSamples-1 -> WAIT_OUT, in_cnt wraps to 0. enable drop mid-LOAD ignored; frame completes.
//  WAIT_OUT: sample_ready=0; timer counts cycles. fft_out_valid&fft_out_sop -> SCAN, processing that beat as bin 0.
//   fft_out_valid without sop ignored. timer reaching TIMEOUT -> IDLE, sync_error=1, no report.
//  SCAN: bin counter increments per fft_out_valid beat. Eligible bins MIN_BIN..NSamples/2-1;
//   update peak when fft_out_mag > peak_mag (strict: ties keep lowest bin). Bins >= NSamples/2 ignored.
//   peak_mag/peak_bin cleared at each sop beat.
//   sop beat mid-scan: restart at bin 0, sync_error=1.
//   eop beat at bin NSamples-1 -> REPORT. eop at any other bin -> IDLE, sync_error=1, no report.
//  REPORT: pitch_output_data <= peak_bin (0 if no eligible bin exceeded 0), pitch_output_valid=1 for exactly one
//   cycle, i.e. cycle after eop beat; -> IDLE. pitch_output_data holds until next REPORT.
//  Samples arriving outside LOAD are back-pressured (sample_ready=0), never dropped.
// TESTING
//  1 Reset mid-LOAD (in_cnt=500): all outputs 0 immediately; re-enable -> next frame sop on first transfer, in_cnt from 0.
//  2 1024 samples with random sample_valid/fft_in_ready stalls -> exactly 1024 transfers, sop on #0, eop on #1023 only.
//  3 Output frame, mag=100 everywhere, 9000 at bin 23 -> pitch_output_data=23, valid 1 cycle after eop.
//  4 Equal peaks 5000 at bins 40 and 60, 9999 at bin 1 and bin 700 -> reports 40 (MIN_BIN and upper-half exclusions).
//  5 eop at bin 511 -> no pulse, sync_error=1, IDLE; no output frame for 8192 cycles -> IDLE, sync_error stays 1.
//  6 enable=1 continuous, 5 frames of sine at bin 12 -> 5 pulses, each pitch_output_data=12.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: frames NSamples audio samples into one FFT input burst,
// waits for the FFT output frame, and reports the peak-magnitude bin in the
// lower half of the spectrum (from MIN_BIN up) as the detected pitch.
// Everything runs in the fft_clk domain; samples arrive already synchronised.
module fft_frame_scheduler #(
  parameter int NSamples = 1024,
  parameter int W        = 16,
  parameter int MAG_W    = 32,
  parameter int MIN_BIN  = 2,
  parameter int TIMEOUT  = 8192
) (
  input  logic                        fft_clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [W-1:0]                sample_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [W-1:0]                fft_in_data,
  output logic                        fft_in_valid,
  output logic                        fft_in_sop,
  output logic                        fft_in_eop,
  input  logic                        fft_in_ready,
  input  logic [MAG_W-1:0]            fft_out_mag,
  input  logic                        fft_out_valid,
  input  logic                        fft_out_sop,
  input  logic                        fft_out_eop,
  output logic [$clog2(NSamples)-1:0] pitch_output_data,
  output logic                        pitch_output_valid,
  output logic                        sync_error
);

  localparam int AW = $clog2(NSamples);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_BIN   = AW'(NSamples - 1);
  localparam logic [AW-1:0] HALF_BIN   = AW'(NSamples / 2);
  localparam logic [AW-1:0] MIN_BIN_C  = AW'(MIN_BIN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_OUT,
    SCAN,
    REPORT
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]    in_cnt;
  logic [AW-1:0]    bin_cnt;
  logic [AW-1:0]    peak_bin;
  logic [MAG_W-1:0] peak_mag;
  logic [TW-1:0]    timer;

  logic             in_xfer;
  logic             scan_beat;
  logic             err_set;
  logic [AW-1:0]    beat_bin;
  logic [AW-1:0]    base_bin;
  logic [MAG_W-1:0] base_mag;
  logic             peak_hit;
  logic [AW-1:0]    new_bin;
  logic [MAG_W-1:0] new_mag;

  // State register; reset returns the scheduler to IDLE at any time
  always_ff @(posedge fft_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the combinational LOAD pass-through and strobes
  always_comb begin
    state_next         = state;
    sample_ready       = 1'b0;
    fft_in_data        = '0;
    fft_in_valid       = 1'b0;
    fft_in_sop         = 1'b0;
    fft_in_eop         = 1'b0;
    in_xfer            = 1'b0;
    scan_beat          = 1'b0;
    err_set            = 1'b0;
    pitch_output_valid = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = LOAD;
      end
      LOAD: begin
        fft_in_data  = sample_data;
        fft_in_valid = sample_valid;
        sample_ready = fft_in_ready;
        fft_in_sop   = sample_valid && (in_cnt == '0);
        fft_in_eop   = sample_valid && (in_cnt == LAST_BIN);
        in_xfer      = sample_valid && fft_in_ready;
        if (in_xfer && (in_cnt == LAST_BIN)) state_next = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (fft_out_valid && fft_out_sop) begin
          scan_beat  = 1'b1;
          state_next = SCAN;
        end else if (timer == TIMER_LAST) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (fft_out_valid) begin
          scan_beat = 1'b1;
          if (fft_out_sop) begin
            err_set = 1'b1;
          end else if (fft_out_eop) begin
            if (bin_cnt == LAST_BIN) begin
              state_next = REPORT;
            end else begin
              err_set    = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      REPORT: begin
        pitch_output_valid = 1'b1;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Peak candidate for the current beat; a sop beat restarts from bin 0 with a cleared peak
  always_comb begin
    beat_bin = fft_out_sop ? '0 : bin_cnt;
    base_bin = fft_out_sop ? '0 : peak_bin;
    base_mag = fft_out_sop ? '0 : peak_mag;
    peak_hit = (beat_bin >= MIN_BIN_C) && (beat_bin < HALF_BIN) && (fft_out_mag > base_mag);
    new_bin  = peak_hit ? beat_bin : base_bin;
    new_mag  = peak_hit ? fft_out_mag : base_mag;
  end

  // Frame counters, peak tracker, reported pitch and the sticky error flag
  always_ff @(posedge fft_clk or negedge reset) begin
    if (!reset) begin
      in_cnt            <= '0;
      bin_cnt           <= '0;
      peak_bin          <= '0;
      peak_mag          <= '0;
      timer             <= '0;
      pitch_output_data <= '0;
      sync_error        <= 1'b0;
    end else begin
      if (in_xfer) in_cnt <= in_cnt + AW'(1);
      if (state == WAIT_OUT) timer <= timer + TW'(1);
      else                   timer <= '0;
      if (scan_beat) begin
        bin_cnt  <= beat_bin + AW'(1);
        peak_bin <= new_bin;
        peak_mag <= new_mag;
      end
      if (state_next == REPORT) pitch_output_data <= new_bin;
      if (err_set) sync_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: directed bench for fft_frame_scheduler covering reset,
// input framing under stalls, peak selection rules, sync errors and timeout.
module tb_fft_frame_scheduler;

  localparam int NS      = 1024;
  localparam int W       = 16;
  localparam int MAG_W   = 32;
  localparam int AW      = 10;

  logic              fft_clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic [W-1:0]      sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic [W-1:0]      fft_in_data;
  logic              fft_in_valid;
  logic              fft_in_sop;
  logic              fft_in_eop;
  logic              fft_in_ready = 1'b0;
  logic [MAG_W-1:0]  fft_out_mag = '0;
  logic              fft_out_valid = 1'b0;
  logic              fft_out_sop = 1'b0;
  logic              fft_out_eop = 1'b0;
  logic [AW-1:0]     pitch_output_data;
  logic              pitch_output_valid;
  logic              sync_error;

  int total = 0;
  int bad = 0;
  int xfers, sopBad, eopBad, dataBad;
  logic v0, v1, v2;
  logic [AW-1:0] d1;

  fft_frame_scheduler #(
    .NSamples(NS), .W(W), .MAG_W(MAG_W), .MIN_BIN(2), .TIMEOUT(8192)
  ) dut (
    .fft_clk(fft_clk),
    .reset(reset),
    .enable(enable),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fft_in_data(fft_in_data),
    .fft_in_valid(fft_in_valid),
    .fft_in_sop(fft_in_sop),
    .fft_in_eop(fft_in_eop),
    .fft_in_ready(fft_in_ready),
    .fft_out_mag(fft_out_mag),
    .fft_out_valid(fft_out_valid),
    .fft_out_sop(fft_out_sop),
    .fft_out_eop(fft_out_eop),
    .pitch_output_data(pitch_output_data),
    .pitch_output_valid(pitch_output_valid),
    .sync_error(sync_error)
  );

  // Free-running 100 MHz FFT clock
  always #5 fft_clk = ~fft_clk;

  // One comparison: counts it and reports a mismatch with observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Magnitude pattern per test: 0 single peak at 23, 1 ties/exclusions, 2 sine at bin 12
  function automatic logic [31:0] magOf(input int pat, input int b);
    case (pat)
      0: return (b == 23) ? 32'd9000 : 32'd100;
      1: begin
        if (b == 40 || b == 60) return 32'd5000;
        if (b == 1 || b == 700) return 32'd9999;
        return 32'd100;
      end
      default: begin
        if (b == 12 || b == NS - 12) return 32'd50000;
        if (b == 11 || b == 13) return 32'd20000;
        return 32'(10 + (b % 7));
      end
    endcase
  endfunction

  // Feeds nXfer samples (optionally with random stalls) and tallies framing errors
  task automatic applyStimulus(input int nXfer, input bit stall, input int dropAt);
    int idx = 0;
    int cyc = 0;
    sopBad = 0; eopBad = 0; dataBad = 0;
    enable = 1'b1;
    while (idx < nXfer && cyc < 20000) begin
      @(negedge fft_clk);
      sample_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      fft_in_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      sample_data  = W'(idx * 7 + 3);
      #1;
      if (sample_valid && sample_ready) begin
        if (fft_in_sop !== (idx == 0)) sopBad++;
        if (fft_in_eop !== (idx == NS - 1)) eopBad++;
        if (fft_in_data !== sample_data || fft_in_valid !== 1'b1) dataBad++;
        idx++;
        if (idx == dropAt) enable = 1'b0;
      end else if (!sample_valid && (fft_in_sop || fft_in_eop || fft_in_valid)) begin
        sopBad++;
      end
      cyc++;
    end
    xfers = idx;
  endtask

  // Plays one FFT output frame ending with eop at lastBin; captures the pulse window
  task automatic driveOutputFrame(input int pat, input int lastBin, input int junk);
    for (int j = 0; j < junk; j++) begin
      @(negedge fft_clk);
      sample_valid  = 1'b0;
      fft_out_valid = 1'b1;
      fft_out_sop   = 1'b0;
      fft_out_eop   = 1'b0;
      fft_out_mag   = 32'hFFFF_FFFF;
    end
    for (int b = 0; b <= lastBin; b++) begin
      @(negedge fft_clk);
      sample_valid = 1'b0;
      if (b % 100 == 37) begin
        fft_out_valid = 1'b0;
        fft_out_sop   = 1'b1;
        fft_out_eop   = 1'b1;
        fft_out_mag   = 32'hFFFF_FFFF;
        @(negedge fft_clk);
      end
      fft_out_valid = 1'b1;
      fft_out_sop   = (b == 0);
      fft_out_eop   = (b == lastBin);
      fft_out_mag   = magOf(pat, b);
    end
    #1 v0 = pitch_output_valid;
    @(negedge fft_clk);
    fft_out_valid = 1'b0;
    fft_out_sop   = 1'b0;
    fft_out_eop   = 1'b0;
    #1;
    v1 = pitch_output_valid;
    d1 = pitch_output_data;
    @(negedge fft_clk);
    #1 v2 = pitch_output_valid;
  endtask

  // Directed test sequence
  initial begin
    sample_valid = 1'b1;
    fft_in_ready = 1'b1;
    enable       = 1'b1;
    repeat (3) @(negedge fft_clk);
    checkOutput("rst_sample_ready", sample_ready, 0);
    checkOutput("rst_in_valid", fft_in_valid, 0);
    checkOutput("rst_pitch_valid", pitch_output_valid, 0);
    checkOutput("rst_pitch_data", pitch_output_data, 0);
    checkOutput("rst_sync_error", sync_error, 0);
    enable = 1'b0;
    reset  = 1'b1;

    $display("[TB] test 1: reset mid-LOAD");
    applyStimulus(500, 1'b1, -1);
    checkOutput("t1_xfers", xfers, 500);
    @(negedge fft_clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("t1_sample_ready", sample_ready, 0);
    checkOutput("t1_in_valid", fft_in_valid, 0);
    checkOutput("t1_in_sop", fft_in_sop, 0);
    checkOutput("t1_in_eop", fft_in_eop, 0);
    checkOutput("t1_sync_error", sync_error, 0);
    @(negedge fft_clk);
    reset = 1'b1;

    $display("[TB] test 2: stalled 1024-sample load");
    applyStimulus(NS, 1'b1, 10);
    checkOutput("t2_xfers", xfers, NS);
    checkOutput("t2_sop_errors", sopBad, 0);
    checkOutput("t2_eop_errors", eopBad, 0);
    checkOutput("t2_data_errors", dataBad, 0);

    $display("[TB] test 3: single peak at bin 23");
    driveOutputFrame(0, NS - 1, 5);
    checkOutput("t3_valid_at_eop", v0, 0);
    checkOutput("t3_valid_after_eop", v1, 1);
    checkOutput("t3_pitch", d1, 23);
    checkOutput("t3_valid_one_cycle", v2, 0);
    checkOutput("t3_sync_error", sync_error, 0);

    $display("[TB] test 4: ties and excluded bins");
    applyStimulus(NS, 1'b0, 1);
    checkOutput("t4_xfers", xfers, NS);
    driveOutputFrame(1, NS - 1, 0);
    checkOutput("t4_valid_after_eop", v1, 1);
    checkOutput("t4_pitch", d1, 40);
    checkOutput("t4_valid_one_cycle", v2, 0);
    checkOutput("t4_sync_error", sync_error, 0);

    $display("[TB] test 5: early eop and output timeout");
    applyStimulus(NS, 1'b0, 1);
    driveOutputFrame(1, 511, 0);
    checkOutput("t5_no_pulse", v1, 0);
    checkOutput("t5_no_pulse_late", v2, 0);
    checkOutput("t5_pitch_hold", d1, 40);
    checkOutput("t5_sync_error", sync_error, 1);
    @(negedge fft_clk);
    sample_valid = 1'b1;
    fft_in_ready = 1'b1;
    #1;
    checkOutput("t5_idle_ready", sample_ready, 0);
    checkOutput("t5_idle_in_valid", fft_in_valid, 0);
    applyStimulus(NS, 1'b0, 1);
    for (int j = 1; j <= 8194; j++) begin
      @(negedge fft_clk);
      if (j == 1) begin
        sample_valid = 1'b0;
        fft_in_ready = 1'b1;
        enable       = 1'b1;
      end
      #1;
      if (j == 8000) checkOutput("t5_wait_hold", sample_ready, 0);
      if (j == 8193) checkOutput("t5_timeout_idle", sample_ready, 0);
      if (j == 8194) checkOutput("t5_timeout_reload", sample_ready, 1);
    end
    checkOutput("t5_sync_sticky", sync_error, 1);
    checkOutput("t5_timeout_no_pulse", pitch_output_valid, 0);

    $display("[TB] test 6: five back-to-back frames");
    for (int f = 0; f < 5; f++) begin
      applyStimulus(NS, 1'b0, -1);
      checkOutput("t6_xfers", xfers, NS);
      checkOutput("t6_sop_errors", sopBad, 0);
      driveOutputFrame(2, NS - 1, 0);
      checkOutput("t6_valid", v1, 1);
      checkOutput("t6_pitch", d1, 12);
      checkOutput("t6_valid_one_cycle", v2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
